// File: rtl/event_capture_unit_pkg.sv
// Shared defaults and constants for the event capture unit.
package event_capture_unit_pkg;

  localparam int unsigned NUM_CH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT  = 8;

  // Saturation value of a counter at the default width.
  localparam int unsigned CNT_MAX = (1 << CNT_W_DEFAULT) - 1;

endpackage

// File: rtl/event_capture_unit_cell.sv
// One event channel: sticky pending/overflow flags, saturating counter and
// snapshot shadow register.
module event_capture_cell
  import event_capture_unit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_in,
  input  logic             ack,
  input  logic             snap,
  output logic             pending,
  output logic             overflow,
  output logic [CNT_W-1:0] shadow,
  output logic             rise
);

  localparam logic [CNT_W-1:0] SAT = '1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             pending_base;
  logic             pending_next;
  logic             overflow_next;
  logic [CNT_W-1:0] count_base;

  // Next-state: ack clears first, then a same-cycle event is counted on top.
  always_comb begin
    pending_base  = ack ? 1'b0 : pending;
    count_base    = ack ? '0 : count;
    overflow_next = ack ? 1'b0 : overflow;
    pending_next  = pending_base;
    count_next    = count_base;
    if (event_in) begin
      pending_next = 1'b1;
      if (count_base == SAT) begin
        overflow_next = 1'b1;
      end else begin
        count_next = count_base + 1'b1;
      end
    end
    // Rise is judged against the post-ack value so an ack+event re-arms.
    rise = pending_next & ~pending_base;
  end

  // Channel state and shadow; shadow captures the count held before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      shadow   <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
      count    <= count_next;
      if (snap) begin
        shadow <= count;
      end
    end
  end

endmodule

// File: rtl/event_capture_unit.sv
// Event capture unit top: per-channel cell array, new-event pulse,
// snapshot acknowledge and snapshot readout mux.
module event_capture_unit
  import event_capture_unit_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         event_in,
  input  logic [NUM_CH-1:0]         ack_trig,
  input  logic                      snap_trig,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  output logic [NUM_CH-1:0]         pending_out,
  output logic [NUM_CH-1:0]         overflow_out,
  output logic [CNT_W-1:0]          count_out,
  output logic                      snap_done,
  output logic                      new_event_trig
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] rise;
  logic [CNT_W-1:0]  shadow_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
    event_capture_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk      (sys_clk),
      .reset    (reset),
      .event_in (event_in[g]),
      .ack      (ack_trig[g]),
      .snap     (snap_trig),
      .pending  (pending_out[g]),
      .overflow (overflow_out[g]),
      .shadow   (shadow_arr[g]),
      .rise     (rise[g])
    );
  end

  // One-cycle pulses: any pending rise, and snapshot acknowledge.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      new_event_trig <= 1'b0;
      snap_done      <= 1'b0;
    end else begin
      new_event_trig <= |rise;
      snap_done      <= snap_trig;
    end
  end

  // Snapshot readout; unmatched select values read as zero.
  always_comb begin
    count_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        count_out = shadow_arr[i];
      end
    end
  end

endmodule

// File: tb/tb_event_capture_unit.sv
// Directed self-checking bench for event_capture_unit (8 channels, 8-bit counts).
module tb_event_capture_unit;
  import event_capture_unit_pkg::*;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [7:0] event_in;
  logic [7:0] ack_trig;
  logic       snap_trig;
  logic [2:0] sel;
  logic [7:0] pending_out;
  logic [7:0] overflow_out;
  logic [7:0] count_out;
  logic       snap_done;
  logic       new_event_trig;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  event_capture_unit #(
    .NUM_CH(8),
    .CNT_W (8)
  ) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .event_in       (event_in),
    .ack_trig       (ack_trig),
    .snap_trig      (snap_trig),
    .sel            (sel),
    .pending_out    (pending_out),
    .overflow_out   (overflow_out),
    .count_out      (count_out),
    .snap_done      (snap_done),
    .new_event_trig (new_event_trig)
  );

  typedef struct {
    logic [7:0] ev;
    logic [7:0] ack;
    logic       snap;
    logic [2:0] sel;
    logic [7:0] pend;
    logic [7:0] ovf;
    logic [7:0] cnt;
    logic       sd;
    logic       ne;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ev, input logic [7:0] ack, input logic snap, input logic [2:0] s);
    event_in  = ev;
    ack_trig  = ack;
    snap_trig = snap;
    sel       = s;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pend, input logic [7:0] ovf,
                         input logic [7:0] cnt, input logic sd, input logic ne);
    chk({tag, ".pending"},   pending_out,    pend);
    chk({tag, ".overflow"},  overflow_out,   ovf);
    chk({tag, ".count_out"}, count_out,      cnt);
    chk({tag, ".snap_done"}, snap_done,      sd);
    chk({tag, ".new_event"}, new_event_trig, ne);
  endtask

  initial begin
    //            ev     ack    snap  sel   pend   ovf    cnt    sd    ne
    tbl[0]  = '{8'h04, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'd0, 1'b0, 1'b1};
    tbl[1]  = '{8'h04, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h04, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'd0, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 3'd2, 8'h04, 8'h00, 8'd3, 1'b1, 1'b0};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 3'd2, 8'h04, 8'h00, 8'd3, 1'b0, 1'b0};
    tbl[5]  = '{8'hFF, 8'h00, 1'b0, 3'd2, 8'hFF, 8'h00, 8'd3, 1'b0, 1'b1};
    tbl[6]  = '{8'h00, 8'h00, 1'b1, 3'd7, 8'hFF, 8'h00, 8'd1, 1'b1, 1'b0};
    tbl[7]  = '{8'h00, 8'h00, 1'b1, 3'd2, 8'hFF, 8'h00, 8'd4, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 8'hFF, 1'b0, 3'd2, 8'h00, 8'h00, 8'd4, 1'b0, 1'b0};
    tbl[9]  = '{8'h20, 8'h20, 1'b0, 3'd2, 8'h20, 8'h00, 8'd4, 1'b0, 1'b1};
    tbl[10] = '{8'h20, 8'h20, 1'b0, 3'd2, 8'h20, 8'h00, 8'd4, 1'b0, 1'b1};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 3'd5, 8'h20, 8'h00, 8'd1, 1'b1, 1'b0};

    // Reset state
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 3'd0);
    tick();
    tick();
    chk_all("reset", 8'h00, 8'h00, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Table: first event lands on the first edge with reset low
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ev, tbl[i].ack, tbl[i].snap, tbl[i].sel);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].pend, tbl[i].ovf, tbl[i].cnt, tbl[i].sd, tbl[i].ne);
    end

    // Saturation on ch0 and clear by ack
    drive(8'h00, 8'hFF, 1'b0, 3'd0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(8'h01, 8'h00, 1'b0, 3'd0);
      tick();
      if (i == 254) chk("sat.ovf_at_255", overflow_out[0], 1'b0);
      if (i == 255) chk("sat.ovf_at_256", overflow_out[0], 1'b1);
    end
    drive(8'h00, 8'h00, 1'b1, 3'd0);
    tick();
    chk("sat.count_out", count_out, CNT_MAX);
    chk("sat.overflow", overflow_out, 8'h01);
    chk("sat.pending", pending_out, 8'h01);
    drive(8'h00, 8'h01, 1'b0, 3'd0);
    tick();
    chk("sat.ack_pending", pending_out, 8'h00);
    chk("sat.ack_overflow", overflow_out, 8'h00);
    drive(8'h00, 8'h00, 1'b1, 3'd0);
    tick();
    chk("sat.ack_count", count_out, 8'd0);

    // Snapshot coincident with an event takes the pre-event count
    for (int i = 0; i < 7; i++) begin
      drive(8'h02, 8'h00, 1'b0, 3'd1);
      tick();
    end
    drive(8'h02, 8'h00, 1'b1, 3'd1);
    tick();
    chk("snapev.count_out", count_out, 8'd7);
    chk("snapev.snap_done", snap_done, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 3'd1);
    tick();
    chk("snapev.done_clear", snap_done, 1'b0);
    chk("snapev.shadow_hold", count_out, 8'd7);
    drive(8'h00, 8'h00, 1'b1, 3'd1);
    tick();
    chk("snapev.live", count_out, 8'd8);

    // Reset dominates same-cycle events and snapshot
    reset = 1'b1;
    drive(8'hFF, 8'h00, 1'b1, 3'd1);
    tick();
    chk_all("rstdom", 8'h00, 8'h00, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 3'd1);
    tick();
    chk_all("rstdom.after", 8'h00, 8'h00, 8'd0, 1'b0, 1'b0);
    drive(8'h08, 8'h00, 1'b0, 3'd3);
    tick();
    chk_all("rstdom.first", 8'h08, 8'h00, 8'd0, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 1'b1, 3'd3);
    tick();
    chk_all("rstdom.snap", 8'h08, 8'h00, 8'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
